// File: rtl/rew_rw_mask_xor_if.sv
// Mask-XOR stream bundle: RW mask beats in, plaintext bucket beats in,
// ciphertext beats out toward the DDR3 write FIFO.
interface rew_rw_mask_xor_if #(
  parameter int DDRDWidth = 512
);
  logic [DDRDWidth-1:0] mask_in;
  logic                 mask_in_valid;
  logic                 mask_in_ready;
  logic [DDRDWidth-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [DDRDWidth-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic                 bucket_last;

  // The block that produces the handshakes toward the mask/data sources and the ciphertext sink
  modport master (
    output mask_in, mask_in_valid, data_in, data_in_valid, data_out_ready,
    input  mask_in_ready, data_in_ready, data_out, data_out_valid, bucket_last
  );

  // The mask-XOR block itself
  modport slave (
    input  mask_in, mask_in_valid, data_in, data_in_valid, data_out_ready,
    output mask_in_ready, data_in_ready, data_out, data_out_valid, bucket_last
  );
endinterface

// File: rtl/rew_rw_mask_xor.sv
// rew_rw_mask_xor: joins one RW mask beat with one plaintext bucket beat,
// XORs them and registers the ciphertext. Header beats of a bucket use only
// the low HdrMaskWidth mask bits; the upper plaintext bits pass unchanged.
// Optional feature macro: REW_MASK_STALL_CNT_EN builds a 16-bit saturating
// count of cycles where plaintext waited on a missing mask beat.
module rew_rw_mask_xor #(
  parameter int DDRDWidth    = 512,
  parameter int BktBeats     = 4,
  parameter int HdrBeats     = 1,
  parameter int HdrMaskWidth = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rew_rw_mask_xor_if.slave     bus,
  output logic [15:0]          mask_stall_count
);

  localparam int CntW = $clog2(BktBeats);
  localparam logic [CntW-1:0] LastCnt = CntW'(BktBeats - 1);
  localparam logic [CntW-1:0] HdrLastCnt = CntW'(HdrBeats - 1);
  localparam logic [DDRDWidth-1:0] HdrKeep =
    {DDRDWidth{1'b1}} >> (DDRDWidth - HdrMaskWidth);

  typedef enum logic {
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  state_t               state_q, state_d;
  logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DDRDWidth-1:0] data_out_q, data_out_d;
  logic                 data_out_valid_q, data_out_valid_d;
  logic                 bucket_last_q, bucket_last_d;
  logic                 slot_free;
  logic                 fire;
  logic [DDRDWidth-1:0] eff_mask;

  // Join both input streams when the output register can take a beat; held off during reset
  always_comb begin
    slot_free = ~data_out_valid_q | bus.data_out_ready;
    fire      = rst_n & bus.mask_in_valid & bus.data_in_valid & slot_free;
  end

  assign bus.mask_in_ready  = fire;
  assign bus.data_in_ready  = fire;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.bucket_last    = bucket_last_q;

  // Header beats discard the unused upper mask bits instead of XORing them
  always_comb begin
    eff_mask = bus.mask_in;
    if (state_q == ST_HEADER) begin
      eff_mask = bus.mask_in & HdrKeep;
    end
  end

  // Bucket framing: count beats, leave header after HdrBeats, re-enter header on wrap
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (fire) begin
      if (beat_cnt_q == LastCnt) begin
        beat_cnt_d = '0;
        state_d    = ST_HEADER;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        if (state_q == ST_HEADER && beat_cnt_q == HdrLastCnt) begin
          state_d = ST_PAYLOAD;
        end
      end
    end
  end

  // Output register: load on a join, drain when downstream accepts, otherwise hold
  always_comb begin
    data_out_d       = data_out_q;
    data_out_valid_d = data_out_valid_q;
    bucket_last_d    = bucket_last_q;
    if (fire) begin
      data_out_d       = bus.data_in ^ eff_mask;
      data_out_valid_d = 1'b1;
      bucket_last_d    = (beat_cnt_q == LastCnt);
    end else if (bus.data_out_ready) begin
      data_out_valid_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously so a held beat is lost on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_HEADER;
      beat_cnt_q       <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      bucket_last_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      bucket_last_q    <= bucket_last_d;
    end
  end

`ifdef REW_MASK_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where plaintext could have gone out but its mask had not arrived
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.data_in_valid && !bus.mask_in_valid && slot_free && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mask_stall_count = stall_cnt_q;
`else
  assign mask_stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_rew_rw_mask_xor.sv
// Self-checking bench for rew_rw_mask_xor: directed test-plan steps followed
// by a long randomized run, all compared against a beat-level reference model.
module tb_rew_rw_mask_xor;

  localparam int W   = 512;
  localparam int BKT = 4;
  localparam int HDR = 1;

  logic        clk;
  logic        rst_n;
  logic [15:0] mask_stall_count;

  rew_rw_mask_xor_if #(.DDRDWidth(W)) bus ();

  rew_rw_mask_xor #(
    .DDRDWidth(W), .BktBeats(BKT), .HdrBeats(HDR), .HdrMaskWidth(256)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .mask_stall_count(mask_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the bucket position is simply the number of accepted beats modulo BKT
  logic [W-1:0] hdr_keep;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_last;
  int           m_accepted;
  int           m_stall;
  int           last_seen;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_data     = '0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_accepted = 0;
    m_stall    = 0;
  endtask

  function automatic logic [W-1:0] rand512();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic applyStimulus(input logic mv, input logic [W-1:0] m, input logic dv,
                               input logic [W-1:0] d, input logic dr);
    bus.mask_in_valid  = mv;
    bus.mask_in        = m;
    bus.data_in_valid  = dv;
    bus.data_in        = d;
    bus.data_out_ready = dr;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_data"}, bus.data_out, m_data);
    checkOutput({tag, "_valid"}, W'(bus.data_out_valid), W'(m_valid));
    checkOutput({tag, "_last"}, W'(bus.bucket_last), W'(m_last));
`ifdef REW_MASK_STALL_CNT_EN
    checkOutput({tag, "_stall"}, W'(mask_stall_count), W'(m_stall));
`else
    checkOutput({tag, "_stall"}, W'(mask_stall_count), W'(0));
`endif
  endtask

  // One clock: check readies before the edge, advance the model at the edge, check outputs after
  task automatic cycle(input string tag, input bit full_check);
    logic fire, slot;
    logic [W-1:0] mask;
    int idx;
    #1;
    slot = !m_valid || bus.data_out_ready;
    fire = rst_n && bus.mask_in_valid && bus.data_in_valid && slot;
    if (full_check) begin
      checkOutput({tag, "_mrdy"}, W'(bus.mask_in_ready), W'(fire));
      checkOutput({tag, "_drdy"}, W'(bus.data_in_ready), W'(fire));
    end
    if (bus.data_out_valid && bus.data_out_ready && bus.bucket_last) last_seen++;
    @(posedge clk);
    if (rst_n) begin
      if (bus.data_in_valid && !bus.mask_in_valid && slot && m_stall < 65535) m_stall++;
      if (fire) begin
        idx  = m_accepted % BKT;
        mask = (idx < HDR) ? (bus.mask_in & hdr_keep) : bus.mask_in;
        m_data  = bus.data_in ^ mask;
        m_valid = 1'b1;
        m_last  = (idx == BKT - 1);
        m_accepted++;
      end else if (bus.data_out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    if (full_check) checkAll(tag);
    @(negedge clk);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("reset_now");
    checkOutput("reset_mrdy", W'(bus.mask_in_ready), W'(0));
    checkOutput("reset_drdy", W'(bus.data_in_ready), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] ones, zeros, a5, mk, dt, held;
    int guard;
    ones  = '1;
    zeros = '0;
    hdr_keep = ones >> 256;
    for (int i = 0; i < W / 8; i++) a5[i*8 +: 8] = 8'hA5;
    modelReset();
    last_seen = 0;
    applyStimulus(1'b1, ones, 1'b1, zeros, 1'b1);
    rst_n = 1'b0;
    #3;
    checkAll("por");
    checkOutput("por_mrdy", W'(bus.mask_in_ready), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single bucket, all-ones mask over zero data");
    for (int b = 0; b < BKT; b++) begin
      cycle("single", 1'b1);
      if (b == 0) checkOutput("single_hdr_beat", bus.data_out, hdr_keep);
      if (b == BKT - 1) checkOutput("single_last_beat", bus.data_out, ones);
    end
    applyStimulus(1'b0, zeros, 1'b0, zeros, 1'b1);
    cycle("single_drain", 1'b1);

    $display("[TB] two back-to-back buckets");
    for (int b = 0; b < 2 * BKT; b++) begin
      dt = W'(b);
      applyStimulus(1'b1, a5, 1'b1, dt, 1'b1);
      cycle("b2b", 1'b1);
      if (b == BKT) checkOutput("b2b_rehdr_upper", W'(bus.data_out[W-1:256]), W'(dt[W-1:256]));
    end
    applyStimulus(1'b0, zeros, 1'b0, zeros, 1'b1);
    cycle("b2b_drain", 1'b1);

    $display("[TB] downstream backpressure for three cycles");
    pulseReset();
    applyStimulus(1'b1, a5, 1'b1, W'(7), 1'b1);
    cycle("bp_first", 1'b1);
    held = bus.data_out;
    applyStimulus(1'b1, a5, 1'b1, W'(8), 1'b0);
    for (int c = 0; c < 3; c++) begin
      cycle("bp_hold", 1'b1);
      checkOutput("bp_stable", bus.data_out, held);
    end
    applyStimulus(1'b1, a5, 1'b1, W'(8), 1'b1);
    cycle("bp_release", 1'b1);
    applyStimulus(1'b0, zeros, 1'b0, zeros, 1'b1);
    cycle("bp_drain", 1'b1);

    $display("[TB] plaintext waiting on masks for ten cycles");
    pulseReset();
    applyStimulus(1'b0, zeros, 1'b1, W'(3), 1'b1);
    for (int c = 0; c < 10; c++) cycle("gap", 1'b1);
`ifdef REW_MASK_STALL_CNT_EN
    checkOutput("gap_stall_10", W'(mask_stall_count), W'(10));
`else
    checkOutput("gap_stall_0", W'(mask_stall_count), W'(0));
`endif
    applyStimulus(1'b1, ones, 1'b1, W'(3), 1'b1);
    cycle("gap_resume", 1'b1);

    $display("[TB] reset pulsed mid-bucket");
    pulseReset();
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b1, rand512(), 1'b1, rand512(), 1'b0);
      bus.data_out_ready = 1'b1;
      cycle("mid", 1'b1);
    end
    pulseReset();
    applyStimulus(1'b1, ones, 1'b1, zeros, 1'b1);
    cycle("mid_after", 1'b1);
    checkOutput("mid_after_hdr", bus.data_out, hdr_keep);

    $display("[TB] randomized run, 1000 buckets");
    pulseReset();
    last_seen = 0;
    guard = 0;
    while (m_accepted < 1000 * BKT && guard < 40000) begin
      mk = rand512();
      dt = rand512();
      applyStimulus(1'($urandom_range(0, 9) < 7), mk, 1'($urandom_range(0, 9) < 7), dt,
                    1'($urandom_range(0, 9) < 7));
      cycle("rnd", 1'b1);
      guard++;
    end
    checkOutput("rnd_budget", W'(m_accepted), W'(1000 * BKT));
    applyStimulus(1'b0, zeros, 1'b0, zeros, 1'b1);
    cycle("rnd_drain", 1'b1);
    cycle("rnd_drain2", 1'b1);
    checkOutput("rnd_last_count", W'(last_seen), W'(1000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
